// File: rtl/disp_demux.sv
// disp_demux: captures stable digits from a multiplexed active-low 7-seg bus into per-digit registers.
// Optional SSEG_DECODE_EN adds a registered segment-to-hex decoder (hex0..hex3, hex_err).
module disp_demux #(
   parameter int STABLE_CYC = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] an,
   input  logic [7:0] sseg,
   input  logic       clr,
   output logic [7:0] led0,
   output logic [7:0] led1,
   output logic [7:0] led2,
   output logic [7:0] led3,
   output logic [3:0] dig_vld,
   output logic       frame_tick,
   output logic       an_err
`ifdef SSEG_DECODE_EN
   ,
   output logic [3:0] hex0,
   output logic [3:0] hex1,
   output logic [3:0] hex2,
   output logic [3:0] hex3,
   output logic [3:0] hex_err
`endif
);
   logic [3:0]  ra;
   logic [7:0]  rs;
   logic [11:0] prev;
   logic [7:0]  cnt;
   logic [3:0]  mask;
   logic        same;
   logic        cap;
   logic        legal;
   logic [3:0]  an_n;
   logic [3:0]  sel;
   logic [3:0]  vld_nxt;
   logic [3:0]  mask_nxt;
   logic        tick_nxt;
   always_comb begin
      same     = {ra, rs} == prev;
      cap      = same && cnt == 8'(STABLE_CYC - 2);
      an_n     = ~ra;
      legal    = an_n != 4'd0 && (an_n & (an_n - 4'd1)) == 4'd0;
      sel      = (cap && legal) ? an_n : 4'd0;
      vld_nxt  = clr ? sel : dig_vld | sel;
      mask_nxt = clr ? sel : mask | sel;
      tick_nxt = mask_nxt == 4'hF;
   end
   // prev resets to a value unequal to the reset sample so the reset edge starts a fresh run
   always_ff @(posedge clk) begin
      if (reset) begin
         ra         <= 4'hF;
         rs         <= 8'hFF;
         prev       <= 12'h000;
         cnt        <= 8'd0;
         mask       <= 4'd0;
         led0       <= 8'hFF;
         led1       <= 8'hFF;
         led2       <= 8'hFF;
         led3       <= 8'hFF;
         dig_vld    <= 4'd0;
         frame_tick <= 1'b0;
         an_err     <= 1'b0;
      end else begin
         ra         <= an;
         rs         <= sseg;
         prev       <= {ra, rs};
         cnt        <= !same ? 8'd0 : (cnt == 8'(STABLE_CYC - 1) ? cnt : cnt + 8'd1);
         led0       <= sel[0] ? rs : led0;
         led1       <= sel[1] ? rs : led1;
         led2       <= sel[2] ? rs : led2;
         led3       <= sel[3] ? rs : led3;
         dig_vld    <= vld_nxt;
         mask       <= tick_nxt ? 4'd0 : mask_nxt;
         frame_tick <= tick_nxt;
         an_err     <= cap && !legal;
      end
   end
`ifdef SSEG_DECODE_EN
   // active-low abcdefg patterns for F..0, entry 0 at the LSBs
   localparam logic [111:0] PAT = {7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
                                   7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01};
   function automatic logic [4:0] dec(input logic [6:0] s);
      logic [4:0] r;
      r = 5'h10;
      for (int i = 0; i < 16; i++)
         if (s == PAT[i*7 +: 7]) r = {1'b0, 4'(i)};
      return r;
   endfunction
   logic [4:0] d;
   always_comb d = dec(rs[6:0]);
   always_ff @(posedge clk) begin
      if (reset) begin
         hex0    <= 4'd0;
         hex1    <= 4'd0;
         hex2    <= 4'd0;
         hex3    <= 4'd0;
         hex_err <= 4'hF;
      end else begin
         hex0    <= sel[0] ? d[3:0] : hex0;
         hex1    <= sel[1] ? d[3:0] : hex1;
         hex2    <= sel[2] ? d[3:0] : hex2;
         hex3    <= sel[3] ? d[3:0] : hex3;
         hex_err <= (hex_err & ~sel) | (sel & {4{d[4]}});
      end
   end
`endif
endmodule

// File: tb/tb_disp_demux.sv
// tb_disp_demux: directed and random stimulus against a run-length history model of disp_demux.
module tb_disp_demux;
   localparam int S = 4;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clr = 1'b0;
   logic [3:0] an = 4'hF;
   logic [7:0] sseg = 8'hFF;
   logic [7:0] led0, led1, led2, led3;
   logic [3:0] dig_vld;
   logic       frame_tick, an_err;
`ifdef SSEG_DECODE_EN
   logic [3:0] hex0, hex1, hex2, hex3, hex_err;
`endif
   int tests = 0;
   int fails = 0;
   int ticks = 0;
   int errs = 0;
   logic [7:0]  e_led [4];
   logic [3:0]  e_hex [4];
   logic [3:0]  e_vld, e_mask, e_herr;
   logic        e_tick, e_err;
   logic [11:0] q [$];
   // active-high abcdefg for hex 0..F; the bus carries the complement
   logic [6:0]  hi_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   disp_demux #(.STABLE_CYC(S)) dut (
      .clk(clk), .reset(reset), .an(an), .sseg(sseg), .clr(clr),
      .led0(led0), .led1(led1), .led2(led2), .led3(led3),
      .dig_vld(dig_vld), .frame_tick(frame_tick), .an_err(an_err)
`ifdef SSEG_DECODE_EN
      , .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex_err(hex_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] pat(input int h, input bit dp);
      logic [6:0] t;
      t = ~hi_tab[h];
      return {~dp, t};
   endfunction

   task automatic step(input logic [3:0] a, input logic [7:0] s, input logic c, input logic r);
      bit cap;
      int n, z, idx;
      logic [3:0] sel;
      logic [6:0] t;
      an = a; sseg = s; clr = c; reset = r;
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 4; i++) begin e_led[i] = 8'hFF; e_hex[i] = 4'd0; end
         e_vld = 0; e_mask = 0; e_herr = 4'hF; e_tick = 0; e_err = 0;
         q.delete();
         q.push_back(12'hFFF);
      end else begin
         n = q.size();
         cap = 0;
         if (n >= S) begin
            cap = 1;
            for (int i = 1; i < S; i++) if (q[n-1-i] != q[n-1]) cap = 0;
            if (n > S && q[n-1-S] == q[n-1]) cap = 0;
         end
         z = 0; idx = 0;
         for (int i = 0; i < 4; i++) if (!q[n-1][8+i]) begin z++; idx = i; end
         sel = 0;
         if (cap && z == 1) begin
            sel = 4'(1 << idx);
            e_led[idx] = q[n-1][7:0];
            e_hex[idx] = 0; e_herr[idx] = 1;
            for (int k = 0; k < 16; k++) begin
               t = ~hi_tab[k];
               if (t == q[n-1][6:0]) begin e_hex[idx] = 4'(k); e_herr[idx] = 0; end
            end
         end
         e_err = cap && z != 1;
         e_vld  = c ? sel : e_vld | sel;
         e_mask = c ? sel : e_mask | sel;
         e_tick = e_mask == 4'hF;
         if (e_tick) e_mask = 0;
         q.push_back({a, s});
         if (q.size() > S + 1) void'(q.pop_front());
      end
      #1;
      check("led0", led0, e_led[0]);
      check("led1", led1, e_led[1]);
      check("led2", led2, e_led[2]);
      check("led3", led3, e_led[3]);
      check("dig_vld", dig_vld, e_vld);
      check("frame_tick", frame_tick, e_tick);
      check("an_err", an_err, e_err);
`ifdef SSEG_DECODE_EN
      check("hex0", hex0, e_hex[0]);
      check("hex1", hex1, e_hex[1]);
      check("hex2", hex2, e_hex[2]);
      check("hex3", hex3, e_hex[3]);
      check("hex_err", hex_err, e_herr);
`endif
      ticks += int'(frame_tick);
      errs += int'(an_err);
   endtask

   task automatic hold(input logic [3:0] a, input logic [7:0] s, input int cyc);
      for (int i = 0; i < cyc; i++) step(a, s, 1'b0, 1'b0);
   endtask

   logic [3:0] dig [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   initial begin
      step(4'hF, 8'hFF, 0, 1);
      step(4'hF, 8'hFF, 0, 1);
      // single digit capture latency
      for (int i = 0; i < 6; i++) begin
         step(4'b1110, 8'b1000_0001, 0, 0);
         if (i == 3) check("lat_pre", led0, 8'hFF);
         if (i == 4) check("lat_led0", led0, 8'h81);
      end
      check("lat_vld", dig_vld, 4'b0001);
`ifdef SSEG_DECODE_EN
      check("lat_hex0", hex0, 4'd0);
      check("lat_herr0", hex_err[0], 1'b0);
`endif
      // unstable bus never captures
      for (int i = 0; i < 4; i++) begin
         hold(4'b1101, 8'hA4, 3);
         hold(4'b1101, 8'h5B, 3);
      end
      check("toggle_led1", led1, 8'hFF);
      check("toggle_vld1", dig_vld[1], 1'b0);
      // full frame
      step(4'hF, 8'hFF, 0, 1);
      ticks = 0;
      for (int d = 0; d < 4; d++) hold(dig[d], pat(d + 1, d == 2), 8);
      check("frame_ticks", ticks, 1);
      check("frame_led0", led0, pat(1, 0));
      check("frame_led3", led3, pat(4, 0));
      hold(dig[0], pat(9, 0), 8);
      check("frame_restart", ticks, 1);
      // illegal an keeps frame progress
      errs = 0;
      hold(4'b1100, pat(7, 0), 6);
      check("illegal_err", errs, 1);
      check("illegal_vld", dig_vld, 4'b1111);
      for (int d = 1; d < 4; d++) hold(dig[d], pat(10 + d, 0), 6);
      check("illegal_mask_kept", ticks, 2);
      // clr coinciding with a capture
      step(4'hF, 8'hFF, 0, 1);
      hold(dig[0], pat(3, 0), 6);
      hold(dig[1], pat(5, 0), 6);
      check("clr_pre", dig_vld, 4'b0011);
      hold(dig[2], pat(6, 0), 4);
      step(dig[2], pat(6, 0), 1, 0);
      check("clr_cap", dig_vld, 4'b0100);
      // reset mid stable period
      hold(dig[3], pat(8, 1), 2);
      step(dig[3], pat(8, 1), 0, 1);
      hold(dig[3], pat(8, 1), 4);
      check("rst_abort", led3, 8'hFF);
      step(dig[3], pat(8, 1), 0, 0);
      check("rst_cap", led3, pat(8, 1));
      // random segments
      for (int seg = 0; seg < 300; seg++) begin
         logic [3:0] a;
         logic [7:0] s;
         int sel_a, len;
         sel_a = $urandom_range(0, 5);
         a = sel_a < 4 ? dig[sel_a] : (sel_a == 4 ? 4'($urandom) : 4'hF);
         s = $urandom_range(0, 1) ? pat($urandom_range(0, 15), 1'($urandom)) : 8'($urandom);
         len = $urandom_range(1, 9);
         if ($urandom_range(0, 39) == 0) step(a, s, 0, 1);
         for (int i = 0; i < len; i++) step(a, s, $urandom_range(0, 19) == 0, 1'b0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
